// File: rtl/ddr3_app_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ddr3_app_arbiter                                              |
// | Purpose  : Arbitrates one write requester and one read requester onto a  |
// |            DDR3 MIG-style app interface. Each write word becomes two     |
// |            data beats (WR1 low half, WR2 high half with wdf_end). Each   |
// |            read word is returned as two beats, which are reassembled.    |
// |            Reads are bounded by an outstanding-command counter.          |
// | Ports    : clk, reset (async, active-high)                               |
// |            wr_req/wr_addr/wr_data -> wr_ack                              |
// |            rd_req/rd_addr -> rd_ack ; rd_data/rd_valid                   |
// |            init_calib_complete                                           |
// |            app_addr/app_cmd/app_en/app_wdf_data/app_wdf_wren/app_wdf_end |
// |            app_rdy/app_wdf_rdy/app_rd_data/app_rd_data_valid/_end        |
// | Options  : DDR_ARB_STATS_EN adds stat_wr_count, stat_rd_count and       |
// |            stat_stall_count (saturating 32-bit counters).                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ddr3_app_arbiter #(
  parameter int pDATA_WIDTH = 32,
  parameter int pADDR_WIDTH = 30,
  parameter int pMAX_RD     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_req,
  input  logic [pADDR_WIDTH-1:0]   wr_addr,
  input  logic [2*pDATA_WIDTH-1:0] wr_data,
  output logic                     wr_ack,
  input  logic                     rd_req,
  input  logic [pADDR_WIDTH-1:0]   rd_addr,
  output logic                     rd_ack,
  output logic [2*pDATA_WIDTH-1:0] rd_data,
  output logic                     rd_valid,
  input  logic                     init_calib_complete,
  output logic [pADDR_WIDTH-1:0]   app_addr,
  output logic [2:0]               app_cmd,
  output logic                     app_en,
  output logic [pDATA_WIDTH-1:0]   app_wdf_data,
  output logic                     app_wdf_wren,
  output logic                     app_wdf_end,
  input  logic                     app_rdy,
  input  logic                     app_wdf_rdy,
  input  logic [pDATA_WIDTH-1:0]   app_rd_data,
  input  logic                     app_rd_data_valid,
  input  logic                     app_rd_data_end
`ifdef DDR_ARB_STATS_EN
 ,output logic [31:0]              stat_wr_count,
  output logic [31:0]              stat_rd_count,
  output logic [31:0]              stat_stall_count
`endif
);

  localparam logic [2:0] cCMD_WR  = 3'b000;
  localparam logic [2:0] cCMD_RD  = 3'b001;
  localparam logic [3:0] cMAX_RD  = 4'(pMAX_RD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR1  = 2'd1,
    WR2  = 2'd2,
    RD   = 2'd3
  } state_t;

  state_t                   state_q;
  logic                     prio_rd_q;      // 1: read wins the next tie
  logic [pADDR_WIDTH-1:0]   app_addr_q;
  logic [2:0]               app_cmd_q;
  logic                     app_en_q;
  logic [pDATA_WIDTH-1:0]   app_wdf_data_q;
  logic                     app_wdf_wren_q;
  logic                     app_wdf_end_q;
  logic [pDATA_WIDTH-1:0]   wr_hi_q;        // upper half held for WR2

  logic [3:0]               outstanding_q;
  logic [3:0]               outstanding_d;
  logic [pDATA_WIDTH-1:0]   rd_lo_q;
  logic [2*pDATA_WIDTH-1:0] rd_data_q;
  logic                     rd_valid_q;

  logic rd_ok;
  logic grant_wr;
  logic grant_rd;
  logic wr_accept;
  logic last_beat;
  logic cnt_inc;
  logic cnt_dec;

  // Grant decision in IDLE: a tie goes to the side not served last, but a
  // read that would exceed the outstanding limit yields to a pending write.
  assign rd_ok    = rd_req && (outstanding_q < cMAX_RD);
  assign grant_wr = init_calib_complete && wr_req && (!prio_rd_q || !rd_ok);
  assign grant_rd = init_calib_complete && rd_ok && !grant_wr;

  assign wr_accept = app_rdy && app_wdf_rdy;
  // Acks are asserted in the acceptance cycle itself, so they are decoded
  // from the registered state and the live ready inputs.
  assign wr_ack    = (state_q == WR2) && wr_accept;
  assign rd_ack    = (state_q == RD) && app_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      prio_rd_q      <= 1'b0;
      app_addr_q     <= '0;
      app_cmd_q      <= 3'b000;
      app_en_q       <= 1'b0;
      app_wdf_data_q <= '0;
      app_wdf_wren_q <= 1'b0;
      app_wdf_end_q  <= 1'b0;
      wr_hi_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          app_en_q       <= 1'b0;
          app_wdf_wren_q <= 1'b0;
          app_wdf_end_q  <= 1'b0;
          if (grant_wr) begin
            state_q        <= WR1;
            prio_rd_q      <= 1'b1;
            app_en_q       <= 1'b1;
            app_cmd_q      <= cCMD_WR;
            app_addr_q     <= wr_addr;
            app_wdf_wren_q <= 1'b1;
            app_wdf_data_q <= wr_data[pDATA_WIDTH-1:0];
            wr_hi_q        <= wr_data[2*pDATA_WIDTH-1:pDATA_WIDTH];
          end else if (grant_rd) begin
            state_q    <= RD;
            prio_rd_q  <= 1'b0;
            app_en_q   <= 1'b1;
            app_cmd_q  <= cCMD_RD;
            app_addr_q <= rd_addr;
          end
        end
        WR1: begin
          if (wr_accept) begin
            state_q        <= WR2;
            app_wdf_end_q  <= 1'b1;
            app_wdf_data_q <= wr_hi_q;
          end
        end
        WR2: begin
          if (wr_accept) begin
            state_q        <= IDLE;
            app_en_q       <= 1'b0;
            app_wdf_wren_q <= 1'b0;
            app_wdf_end_q  <= 1'b0;
          end
        end
        RD: begin
          if (app_rdy) begin
            state_q  <= IDLE;
            app_en_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read return path: independent of the command FSM.
  assign last_beat = app_rd_data_valid && app_rd_data_end;
  assign cnt_inc   = rd_ack && (outstanding_q != 4'hF);
  assign cnt_dec   = last_beat && (outstanding_q != 4'h0);

  always_comb begin
    outstanding_d = outstanding_q;
    if (cnt_inc && !cnt_dec) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (cnt_dec && !cnt_inc) begin
      outstanding_d = outstanding_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_q <= 4'h0;
      rd_lo_q       <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      rd_valid_q    <= 1'b0;
      if (app_rd_data_valid) begin
        if (app_rd_data_end) begin
          rd_data_q  <= {app_rd_data, rd_lo_q};
          rd_valid_q <= 1'b1;
        end else begin
          rd_lo_q <= app_rd_data;
        end
      end
    end
  end

  assign app_addr     = app_addr_q;
  assign app_cmd      = app_cmd_q;
  assign app_en       = app_en_q;
  assign app_wdf_data = app_wdf_data_q;
  assign app_wdf_wren = app_wdf_wren_q;
  assign app_wdf_end  = app_wdf_end_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;

`ifdef DDR_ARB_STATS_EN
  logic [31:0] stat_wr_q;
  logic [31:0] stat_rd_q;
  logic [31:0] stat_stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_wr_q    <= '0;
      stat_rd_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      if (wr_ack && (stat_wr_q != '1)) stat_wr_q <= stat_wr_q + 32'd1;
      if (rd_ack && (stat_rd_q != '1)) stat_rd_q <= stat_rd_q + 32'd1;
      if (app_en_q && !app_rdy && (stat_stall_q != '1)) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
    end
  end

  assign stat_wr_count    = stat_wr_q;
  assign stat_rd_count    = stat_rd_q;
  assign stat_stall_count = stat_stall_q;
`endif

endmodule
`default_nettype wire

// File: doc/ddr3_app_arbiter.md
DDR3_APP_ARBITER -- requirements
Module: ddr3_app_arbiter

Interface
REQ-001 Parameters SHALL be, as name, default, meaning: pDATA_WIDTH, 32, app data beat width; pADDR_WIDTH, 30, app address width; pMAX_RD, 8, maximum outstanding read commands (1..15).
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, the block's single clock.
- reset, in, 1, asynchronous, active-high.
- wr_req, in, 1, write requester has a word.
- wr_addr, in, pADDR_WIDTH, byte address of the write, 8-aligned.
- wr_data, in, 2*pDATA_WIDTH, write word.
- wr_ack, out, 1, one-cycle pulse when the write word is fully accepted.
- rd_req, in, 1, read requester wants a word.
- rd_addr, in, pADDR_WIDTH, byte address of the read, 8-aligned.
- rd_ack, out, 1, one-cycle pulse when the read command is accepted.
- rd_data, out, 2*pDATA_WIDTH, assembled read word.
- rd_valid, out, 1, rd_data valid pulse.
- init_calib_complete, in, 1, DDR ready.
- app_addr, out, pADDR_WIDTH, app address.
- app_cmd, out, 3, 000 = write, 001 = read.
- app_en, out, 1, app command enable.
- app_wdf_data, out, pDATA_WIDTH, app write data beat.
- app_wdf_wren, out, 1, app write data enable.
- app_wdf_end, out, 1, app last write beat.
- app_rdy, in, 1, app command ready.
- app_wdf_rdy, in, 1, app write data ready.
- app_rd_data, in, pDATA_WIDTH, app read data beat.
- app_rd_data_valid, in, 1, app read beat valid.
- app_rd_data_end, in, 1, app last read beat.

Function
REQ-003 FSM states SHALL be IDLE, WR1, WR2, RD; no grant leaves IDLE while init_calib_complete=0.
REQ-004 In IDLE, when only one of wr_req/rd_req is high, that requester SHALL be granted next cycle; when both are high, the requester not granted last SHALL win (round-robin, write wins first tie after reset).
REQ-005 A read grant SHALL additionally require outstanding count < pMAX_RD; otherwise a pending write is served, or the FSM waits in IDLE.
REQ-006 WR1 SHALL drive app_en=1, app_cmd=000, app_addr=wr_addr, app_wdf_wren=1, app_wdf_end=0, app_wdf_data=wr_data[pDATA_WIDTH-1:0], and hold until a cycle with app_rdy and app_wdf_rdy both 1, then go to WR2.
REQ-007 WR2 SHALL drive app_en=1, app_cmd=000, same app_addr, app_wdf_wren=1, app_wdf_end=1, and upper half of wr_data, and hold until a cycle with app_rdy and app_wdf_rdy both 1. In that acceptance cycle wr_ack SHALL pulse and the FSM SHALL return to IDLE.
REQ-008 RD SHALL drive app_en=1, app_cmd=001, app_addr=rd_addr, app_wdf_wren=0 until app_rdy=1. In that cycle rd_ack SHALL pulse, outstanding SHALL increment, and the FSM SHALL return to IDLE.
REQ-009 In IDLE, app_en, app_wdf_wren and app_wdf_end SHALL be 0; wr_addr/wr_data/rd_addr SHALL be sampled when the grant is made, and the requester holds them until ack.
REQ-010 Read beats: a beat with app_rd_data_valid=1 and end=0 SHALL be latched as the low half. A beat with valid=1 and end=1 SHALL, one cycle later, set rd_data={beat, low half}, pulse rd_valid, and decrement outstanding.
REQ-011 Simultaneous increment and decrement of outstanding SHALL leave it unchanged; the counter SHALL never wrap (4 bits).
REQ-012 Read return handling SHALL run independently of the FSM, so writes may proceed while reads are outstanding.
REQ-013 Minimum write latency, wr_req high to wr_ack, SHALL be 3 cycles with app_rdy held at 1; minimum read latency, rd_req high to rd_ack, SHALL be 2 cycles.

Reset
REQ-014 On reset: state=IDLE, outstanding=0, round-robin pointer=write-first, all outputs 0 including rd_data; reset mid-WR1/WR2/RD SHALL abandon the transaction with no ack.

Configuration
REQ-015 With macro DDR_ARB_STATS_EN defined, the block SHALL add outputs stat_wr_count[31:0], stat_rd_count[31:0] and stat_stall_count[31:0]. They count wr_ack pulses, rd_ack pulses, and cycles with app_en=1 and app_rdy=0, saturate at all-ones, and reset to 0. Without the macro, these ports and their logic SHALL be absent.

Verification
REQ-016 wr_req, addr 0x40, data 0x11112222_33334444, app_rdy=1 -> WR1 beat 0x33334444, WR2 beat 0x11112222 with end=1, app_addr 0x40 both beats, wr_ack on 3rd cycle.
REQ-017 wr_req and rd_req both held high from reset -> grants alternate W,R,W,R; 4 acks each in 4 of each.
REQ-018 pMAX_RD=8, app returns no data -> 8 rd_acks, then app_en stays 0 for reads. One beat pair 0xAAAA0001, 0xBBBB0002 returned -> rd_data 0xBBBB0002_AAAA0001, a 9th rd_ack follows.
REQ-019 app_rdy low for 5 cycles during WR2 -> outputs held stable, a single wr_ack after app_rdy rises; stat_stall_count=5 with DDR_ARB_STATS_EN.
REQ-020 reset asserted in WR2 -> all outputs 0 asynchronously, no wr_ack. init_calib_complete=0 after release -> no app_en until it is 1.
